// File: rtl/load_ext_unit.sv
// Load-data formatter for MEM->WB: lane select, sign/zero extension,
// misalignment (AdEL) detection, behind a 2-entry valid/ready skid buffer.
module load_ext_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_LSB = 2,
    parameter int TAG_W    = 5
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_rdata,
    input  logic [ADDR_LSB-1:0] in_addr_lo,
    input  logic [1:0]          in_size,
    input  logic                in_sign,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_adel
);

    localparam logic [DATA_W-1:0] M8  = {{(DATA_W-8){1'b0}}, 8'hFF};
    localparam logic [DATA_W-1:0] M16 = {{(DATA_W-16){1'b0}}, 16'hFFFF};
    localparam logic [DATA_W-1:0] M32 = {{(DATA_W-32){1'b0}}, 32'hFFFF_FFFF};

    logic [DATA_W-1:0] w_sh;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_fmt;
    logic              w_ext;
    logic              w_adel;
    logic              w_acc;
    logic              w_ret;
    logic              w_load_m;

    logic              r_m_vld;
    logic [DATA_W-1:0] r_m_data;
    logic [TAG_W-1:0]  r_m_tag;
    logic              r_m_adel;
    logic              r_s_vld;
    logic [DATA_W-1:0] r_s_data;
    logic [TAG_W-1:0]  r_s_tag;
    logic              r_s_adel;

    // Shift the addressed lane down to bit 0, then mask and extend
    assign w_sh = in_rdata >> {in_addr_lo, 3'b000};

    always_comb begin
        w_mask = '0;
        w_ext  = 1'b0;
        w_adel = 1'b0;
        unique case (in_size)
            2'd0: begin
                w_mask = M8;
                w_ext  = in_sign & w_sh[7];
            end
            2'd1: begin
                w_mask = M16;
                w_ext  = in_sign & w_sh[15];
                w_adel = in_addr_lo[0];
            end
            2'd2: begin
                w_mask = M32;
                w_ext  = in_sign & w_sh[31];
                w_adel = |in_addr_lo[1:0];
            end
            default: begin
                w_mask = '1;
                w_adel = (DATA_W == 32) || (|in_addr_lo);
            end
        endcase
    end

    assign w_fmt = w_adel ? '0
                 : (w_sh & w_mask) | ({DATA_W{w_ext}} & ~w_mask);

    assign in_ready  = !r_s_vld;
    assign out_valid = r_m_vld;
    assign out_data  = r_m_data;
    assign out_tag   = r_m_tag;
    assign out_adel  = r_m_adel;

    assign w_acc    = in_valid & ~r_s_vld & ~flush;
    assign w_ret    = r_m_vld & out_ready;
    assign w_load_m = ~r_m_vld | w_ret;

    // S always drains into M before a fresh beat, keeping FIFO order
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_m_vld  <= 1'b0;
            r_m_data <= '0;
            r_m_tag  <= '0;
            r_m_adel <= 1'b0;
            r_s_vld  <= 1'b0;
            r_s_data <= '0;
            r_s_tag  <= '0;
            r_s_adel <= 1'b0;
        end else if (flush) begin
            r_m_vld <= 1'b0;
            r_s_vld <= 1'b0;
        end else if (w_load_m) begin
            if (r_s_vld) begin
                r_m_vld  <= 1'b1;
                r_m_data <= r_s_data;
                r_m_tag  <= r_s_tag;
                r_m_adel <= r_s_adel;
                r_s_vld  <= 1'b0;
            end else if (w_acc) begin
                r_m_vld  <= 1'b1;
                r_m_data <= w_fmt;
                r_m_tag  <= in_tag;
                r_m_adel <= w_adel;
            end else begin
                r_m_vld <= 1'b0;
            end
        end else if (w_acc) begin
            r_s_vld  <= 1'b1;
            r_s_data <= w_fmt;
            r_s_tag  <= in_tag;
            r_s_adel <= w_adel;
        end
    end

endmodule
